// File: rtl/shared_reg_arb_pkg.sv
// Shared types for the single-owner shared register arbiter.
package shared_reg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Index width for a requester count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            valid_c,
  output logic [IDXW-1:0] idx_c
);

  localparam int unsigned SW = IDXW + 1;

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] shifted;
  logic [NREQ-1:0]   rot;
  logic [IDXW-1:0]   first;
  logic [SW-1:0]     sum;

  // Rotate so ptr sits at bit 0, find the lowest set bit, then rotate back.
  always_comb begin
    dbl     = {req, req};
    shifted = dbl >> ptr;
    rot     = shifted[NREQ-1:0];
    first   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) first = IDXW'(i);
    end
    sum = SW'(ptr) + SW'(first);
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    idx_c   = sum[IDXW-1:0];
    valid_c = |req;
  end

endmodule

// File: rtl/shared_reg_arb.sv
// Sole owner of a shared register; clients win write access round-robin,
// optionally holding it for locked bursts of up to MAX_HOLD writes.
module shared_reg_arb
  import shared_reg_arb_pkg::*;
#(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned MAX_HOLD = 4,
  localparam int unsigned IDXW     = idx_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst1,
  input  logic                  sync_clr,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDXW-1:0]       owner,
  output logic                  busy,
  output logic                  err_hold
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  if (NREQ < 2) begin : g_bad_nreq
    $error("shared_reg_arb: NREQ must be >= 2");
  end
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("shared_reg_arb: MAX_HOLD must be >= 2");
  end

  state_e            state, state_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [IDXW-1:0]   owner_nxt;
  logic [IDXW-1:0]   ptr, ptr_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;
  logic              err_nxt;
  logic              busy_nxt;
  logic              pick_valid;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW-1:0]   ptr_inc;
  logic [WIDTH-1:0]  own_data;
  logic [WIDTH-1:0]  pick_data;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .valid_c (pick_valid),
    .idx_c   (pick_idx)
  );

  assign own_data  = wdata[int'(owner) * int'(WIDTH) +: WIDTH];
  assign pick_data = wdata[int'(pick_idx) * int'(WIDTH) +: WIDTH];
  assign ptr_inc   = (owner == IDXW'(NREQ - 1)) ? '0 : owner + IDXW'(1);

  always_ff @(posedge clk or negedge rst1) begin
    if (!rst1) begin
      state    <= IDLE;
      q        <= '0;
      gnt      <= '0;
      owner    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
      err_hold <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      q        <= q_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      err_hold <= err_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    err_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (sync_clr) begin
          q_nxt   = '0;
          gnt_nxt = '0;
        end else if (pick_valid) begin
          q_nxt     = pick_data;
          gnt_nxt   = NREQ'(1) << pick_idx;
          owner_nxt = pick_idx;
          hold_nxt  = HW'(1);
          state_nxt = OWN;
        end else begin
          gnt_nxt = '0;
        end
      end
      OWN: begin
        // Every exit from OWN moves ptr past the released owner.
        if (sync_clr) begin
          q_nxt     = '0;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_inc;
          state_nxt = IDLE;
        end else if (req[owner] && lock[owner] && (hold_cnt < HW'(MAX_HOLD))) begin
          q_nxt    = own_data;
          hold_nxt = hold_cnt + HW'(1);
        end else begin
          err_nxt   = req[owner] && lock[owner];
          gnt_nxt   = '0;
          ptr_nxt   = ptr_inc;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == OWN);
  end

endmodule

// File: tb/tb_shared_reg_arb.sv
// Bench for shared_reg_arb: directed scenarios plus random traffic vs a reference model.
module tb_shared_reg_arb;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             rst1;
  logic             sync_clr;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]  gnt;
  logic [WIDTH-1:0] q;
  logic [1:0]       owner;
  logic             busy;
  logic             err_hold;

  logic [WIDTH-1:0] wd [NREQ];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit               m_own;
  int               m_owner;
  int               m_ptr;
  int               m_cnt;
  logic [WIDTH-1:0] m_q;
  logic [NREQ-1:0]  m_gnt;
  bit               m_err;

  assign wdata = {wd[3], wd[2], wd[1], wd[0]};

  shared_reg_arb #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk      (clk),
    .rst1     (rst1),
    .sync_clr (sync_clr),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .owner    (owner),
    .busy     (busy),
    .err_hold (err_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_own = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    m_q = '0; m_gnt = '0; m_err = 0;
  endfunction

  // One clock edge of the arbiter, straight from the behavioural rules.
  function automatic void model_edge();
    int w;
    m_err = 0;
    if (sync_clr) begin
      m_q = '0;
      m_gnt = '0;
      if (m_own) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_own = 0;
      end
    end else if (!m_own) begin
      if (req != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        m_q = wd[w];
        m_gnt = '0;
        m_gnt[w] = 1'b1;
        m_owner = w;
        m_cnt = 1;
        m_own = 1;
      end else begin
        m_gnt = '0;
      end
    end else if (req[m_owner] && lock[m_owner] && m_cnt < MAX_HOLD) begin
      m_q = wd[m_owner];
      m_cnt++;
    end else begin
      m_err = req[m_owner] && lock[m_owner];
      m_gnt = '0;
      m_ptr = (m_owner + 1) % NREQ;
      m_own = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst1 = 1'b0;
    model_reset();
    #2;
    rst1 = 1'b1;
  endtask

  task automatic test_reset();
    rst1 = 1'b1; sync_clr = 1'b0; req = 4'hF; lock = '0;
    for (int i = 0; i < NREQ; i++) wd[i] = '0;
    #1 rst1 = 1'b0;
    model_reset();
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    checks++; if (gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (gnt !== 4'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_held: gnt %b busy %b want 0000/0", gnt, busy);
    end
    rst1 = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001 || owner !== 2'd0) begin
      errors++; $display("FAIL reset_first_grant: gnt %b owner %0d want 0001/0", gnt, owner);
    end
  endtask

  task automatic test_single();
    req = '0; lock = '0;
    step(); step();
    req = 4'b0100; wd[2] = 8'hA5;
    step();
    checks++; if (gnt !== 4'b0100 || owner !== 2'd2 || q !== 8'hA5 || busy !== 1'b1) begin
      errors++; $display("FAIL single_write: gnt %b owner %0d q %h busy %b want 0100/2/a5/1", gnt, owner, q, busy);
    end
    req = '0;
    step();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || q !== 8'hA5) begin
      errors++; $display("FAIL single_release: gnt %b busy %b q %h want 0000/0/a5", gnt, busy, q);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    req = 4'hF; lock = '0;
    for (int i = 0; i < NREQ; i++) wd[i] = 8'(8'h10 + i);
    for (int k = 0; k < NREQ; k++) begin
      step();
      checks++; if (gnt !== 4'(1 << k) || q !== 8'(8'h10 + k)) begin
        errors++; $display("FAIL contention_grant%0d: gnt %b q %h want %b/%h", k, gnt, q, 4'(1 << k), 8'(8'h10 + k));
      end
      req[k] = 1'b0;
      step();
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL contention_gap%0d: gnt %b busy %b want 0000/0", k, gnt, busy);
      end
    end
  endtask

  task automatic test_locked_burst();
    req = 4'b1010; lock = 4'b0010;
    for (int n = 1; n <= MAX_HOLD; n++) begin
      wd[1] = 8'(n);
      step();
      checks++; if (q !== 8'(n) || gnt !== 4'b0010 || err_hold !== 1'b0) begin
        errors++; $display("FAIL burst_write%0d: q %h gnt %b err %b want %h/0010/0", n, q, gnt, err_hold, 8'(n));
      end
    end
    wd[1] = 8'(MAX_HOLD + 1);
    step();
    checks++; if (gnt !== 4'b0000 || err_hold !== 1'b1 || q !== 8'(MAX_HOLD)) begin
      errors++; $display("FAIL burst_force_release: gnt %b err %b q %h want 0000/1/%h", gnt, err_hold, q, 8'(MAX_HOLD));
    end
    req[1] = 1'b0; lock[1] = 1'b0; wd[3] = 8'h33;
    step();
    checks++; if (gnt !== 4'b1000 || err_hold !== 1'b0 || q !== 8'h33) begin
      errors++; $display("FAIL burst_next_owner: gnt %b err %b q %h want 1000/0/33", gnt, err_hold, q);
    end
    req[3] = 1'b0;
    step();
  endtask

  task automatic test_sync_clr();
    req = 4'b0001; lock = 4'b0001; wd[0] = 8'h77;
    step();
    checks++; if (q !== 8'h77 || gnt !== 4'b0001) begin
      errors++; $display("FAIL clr_setup: q %h gnt %b want 77/0001", q, gnt);
    end
    sync_clr = 1'b1;
    step();
    checks++; if (q !== 8'h00 || gnt !== 4'b0000 || err_hold !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clr_abort: q %h gnt %b err %b busy %b want 00/0000/0/0", q, gnt, err_hold, busy);
    end
    sync_clr = 1'b0; req = 4'hF; lock = '0; wd[1] = 8'h31;
    step();
    checks++; if (gnt !== 4'b0010 || owner !== 2'd1 || q !== 8'h31) begin
      errors++; $display("FAIL clr_ptr_advance: gnt %b owner %0d q %h want 0010/1/31", gnt, owner, q);
    end
    req = '0;
    step();
  endtask

  task automatic test_midburst_reset();
    req = 4'b0100; lock = 4'b0100; wd[2] = 8'h42; wd[0] = 8'h5A;
    step();
    wd[2] = 8'h43;
    step();
    checks++; if (q !== 8'h43 || busy !== 1'b1) begin
      errors++; $display("FAIL midrst_setup: q %h busy %b want 43/1", q, busy);
    end
    #2 rst1 = 1'b0;
    model_reset();
    #1;
    checks++; if (q !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_async: q %h gnt %b busy %b want 00/0000/0", q, gnt, busy);
    end
    req = 4'b0101; lock = '0;
    #2 rst1 = 1'b1;
    step();
    checks++; if (gnt !== 4'b0001 || owner !== 2'd0 || q !== 8'h5A) begin
      errors++; $display("FAIL midrst_ptr0: gnt %b owner %0d q %h want 0001/0/5a", gnt, owner, q);
    end
    req = '0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        lock[i] = ($urandom_range(0, 3) != 0);
        wd[i]   = 8'($urandom);
      end
      sync_clr = ($urandom_range(0, 15) == 0);
      step();
      checks++; if (gnt !== m_gnt) begin errors++; $display("FAIL rand_gnt c%0d: got %b want %b", c, gnt, m_gnt); end
      checks++; if (q !== m_q) begin errors++; $display("FAIL rand_q c%0d: got %h want %h", c, q, m_q); end
      checks++; if (owner !== 2'(m_owner)) begin errors++; $display("FAIL rand_owner c%0d: got %0d want %0d", c, owner, m_owner); end
      checks++; if (busy !== m_own) begin errors++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, m_own); end
      checks++; if (err_hold !== m_err) begin errors++; $display("FAIL rand_err c%0d: got %b want %b", c, err_hold, m_err); end
    end
    sync_clr = 1'b0; req = '0; lock = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_locked_burst();
    test_sync_clr();
    test_midburst_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
